// File: rtl/rx_scan_if.sv
// Handshake bundle between the UART receiver, the debug controller and rx_scan.
// The slave modport is the scanner's view of the bundle; the master modport is the environment's view.
interface rx_scan_if;
  logic [7:0]  d_rx;
  logic        vld_rx;
  logic        rdy_rx;
  logic        req_rx;
  logic        type_rx;
  logic        ack_rx;
  logic [31:0] din_rx;
  logic        flag_rx;
  logic        err_rx;

  modport slave  (input  d_rx, vld_rx, req_rx, type_rx,
                  output rdy_rx, ack_rx, din_rx, flag_rx, err_rx);
  modport master (output d_rx, vld_rx, req_rx, type_rx,
                  input  rdy_rx, ack_rx, din_rx, flag_rx, err_rx);
endinterface

// File: rtl/rx_scan.sv
// Scans one character or one space/CR-terminated hex number from a UART byte stream.
// Optional macro RX_SCAN_CASE_EN: fold a-z to upper case for characters and accept a-f as hex digits.
module rx_scan #(
  parameter int DIGITS = 8
) (
  input  logic      clk,
  input  logic      rst,
  rx_scan_if.slave  bus
);
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] SP = 8'h20;
  localparam logic [3:0] DIGITS_L = 4'(DIGITS);

  typedef enum logic [2:0] {IDLE, CHAR, SKIP, NUM, DONE} state_t;

  state_t      state;
  logic [31:0] acc;
  logic [3:0]  cnt;
  logic        err;
  logic        rdy;
  logic        xfer;
  logic        hex_ok;
  logic [3:0]  nib;
  logic [7:0]  ch;

  // Decodes one ASCII hex digit; the upper bit flags a legal digit.
  function automatic logic [4:0] hex_nib(input logic [7:0] b);
    if (b >= 8'h30 && b <= 8'h39) return {1'b1, 4'(b - 8'h30)};
    if (b >= 8'h41 && b <= 8'h46) return {1'b1, 4'(b - 8'h37)};
`ifdef RX_SCAN_CASE_EN
    if (b >= 8'h61 && b <= 8'h66) return {1'b1, 4'(b - 8'h57)};
`endif
    return 5'b0;
  endfunction

  // Character path, optionally folded to upper case.
  function automatic logic [7:0] fold(input logic [7:0] b);
`ifdef RX_SCAN_CASE_EN
    if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
`endif
    return b;
  endfunction

  // Gating with rst keeps a byte offered during reset from being consumed.
  always_comb begin
    rdy  = rst && (state == CHAR || state == SKIP || state == NUM);
    xfer = bus.vld_rx && rdy;
    {hex_ok, nib} = hex_nib(bus.d_rx);
    ch = fold(bus.d_rx);
  end

  assign bus.rdy_rx = rdy;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      err         <= 1'b0;
      bus.ack_rx  <= 1'b0;
      bus.din_rx  <= '0;
      bus.flag_rx <= 1'b0;
      bus.err_rx  <= 1'b0;
    end else begin
      bus.ack_rx <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_rx) begin
            state <= bus.type_rx ? SKIP : CHAR;
            acc   <= '0;
            cnt   <= '0;
            err   <= 1'b0;
          end
        end
        CHAR: begin
          if (xfer && bus.d_rx != LF) begin
            bus.din_rx  <= {24'h0, ch};
            bus.flag_rx <= (bus.d_rx == CR);
            bus.err_rx  <= 1'b0;
            bus.ack_rx  <= 1'b1;
            state       <= DONE;
          end
        end
        SKIP, NUM: begin
          // Leading spaces are dropped only before the first significant byte.
          if (xfer && bus.d_rx != LF && !(state == SKIP && bus.d_rx == SP)) begin
            state <= NUM;
            if (bus.d_rx == SP || bus.d_rx == CR) begin
              bus.din_rx  <= acc;
              bus.flag_rx <= (bus.d_rx == CR);
              bus.err_rx  <= err || (cnt == 4'd0);
              bus.ack_rx  <= 1'b1;
              state       <= DONE;
            end else if (hex_ok && cnt < DIGITS_L) begin
              acc <= {acc[27:0], nib};
              cnt <= cnt + 4'd1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        DONE: begin
          if (!bus.req_rx) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rx_scan.sv
// Directed self-checking bench for rx_scan (default build, or with RX_SCAN_CASE_EN defined).
module tb_rx_scan;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  rx_scan_if bus ();
  rx_scan #(.DIGITS(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Offers one byte and returns #1 after the edge on which it transferred.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.d_rx   = b;
    bus.vld_rx = 1'b1;
    @(negedge clk);
    while (!bus.rdy_rx && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rdy_rx) begin
      tests++;
      fails++;
      $error("FAIL rdy_timeout: observed rdy_rx=0 expected 1 within 20 cycles");
    end
    @(posedge clk);
    #1 bus.vld_rx = 1'b0;
  endtask

  task automatic start_txn(input logic t, input string s);
    bus.req_rx  = 1'b1;
    bus.type_rx = t;
    for (int i = 0; i < s.len(); i++) begin
      if (i == s.len() - 1) check("ack_before_last", {31'b0, bus.ack_rx}, 32'd0);
      send_byte(s[i]);
    end
  endtask

  task automatic check_result(input string tag, input logic [31:0] din,
                              input logic flag, input logic err);
    check({tag, "_ack"},  {31'b0, bus.ack_rx},  32'd1);
    check({tag, "_din"},  bus.din_rx,           din);
    check({tag, "_flag"}, {31'b0, bus.flag_rx}, {31'b0, flag});
    check({tag, "_err"},  {31'b0, bus.err_rx},  {31'b0, err});
  endtask

  // Keeps req high for a few cycles after ack, then releases and lets the FSM idle.
  task automatic finish_txn(input int hold);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1 check("no_second_ack", {31'b0, bus.ack_rx}, 32'd0);
    end
    bus.req_rx = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.d_rx    = 8'h00;
    bus.vld_rx  = 1'b0;
    bus.req_rx  = 1'b0;
    bus.type_rx = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy",  {31'b0, bus.rdy_rx},  32'd0);
    check("rst_ack",  {31'b0, bus.ack_rx},  32'd0);
    check("rst_din",  bus.din_rx,           32'd0);
    check("rst_flag", {31'b0, bus.flag_rx}, 32'd0);
    check("rst_err",  {31'b0, bus.err_rx},  32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    start_txn(1'b0, "D");
    check_result("char_D", 32'h0000_0044, 1'b0, 1'b0);
    finish_txn(3);

    start_txn(1'b1, " 1F2A\r");
    check_result("num_1F2A", 32'h0000_1F2A, 1'b1, 1'b0);
    finish_txn(1);

    start_txn(1'b1, "123456789 ");
    check_result("num_overflow", 32'h1234_5678, 1'b0, 1'b1);
    finish_txn(1);

    start_txn(1'b1, "\r");
    check_result("num_empty", 32'h0000_0000, 1'b1, 1'b1);
    finish_txn(1);

    start_txn(1'b1, "1G2 ");
    check_result("num_bad", 32'h0000_0012, 1'b0, 1'b1);
    finish_txn(1);

`ifdef RX_SCAN_CASE_EN
    start_txn(1'b0, "d");
    check_result("char_fold", 32'h0000_0044, 1'b0, 1'b0);
    finish_txn(1);
    start_txn(1'b1, "ab\r");
    check_result("num_lower", 32'h0000_00AB, 1'b1, 1'b0);
    finish_txn(1);
`else
    start_txn(1'b0, "d");
    check_result("char_raw", 32'h0000_0064, 1'b0, 1'b0);
    finish_txn(1);
    start_txn(1'b1, "ab\r");
    check_result("num_lower", 32'h0000_0000, 1'b1, 1'b1);
    finish_txn(1);
`endif

    start_txn(1'b1, "5\n\r");
    check_result("num_lf", 32'h0000_0005, 1'b1, 1'b0);
    finish_txn(0);

    // Reset mid-number with a byte still offered.
    start_txn(1'b1, "12");
    rst        = 1'b0;
    bus.req_rx = 1'b0;
    bus.d_rx   = 8'h33;
    bus.vld_rx = 1'b1;
    @(negedge clk);
    check("rst_mid_rdy_during", {31'b0, bus.rdy_rx}, 32'd0);
    @(posedge clk);
    #1;
    check("rst_mid_ack",  {31'b0, bus.ack_rx},  32'd0);
    check("rst_mid_din",  bus.din_rx,           32'd0);
    check("rst_mid_flag", {31'b0, bus.flag_rx}, 32'd0);
    check("rst_mid_err",  {31'b0, bus.err_rx},  32'd0);
    check("rst_mid_rdy",  {31'b0, bus.rdy_rx},  32'd0);
    bus.vld_rx = 1'b0;
    rst        = 1'b1;
    @(posedge clk);
    #1;
    check("idle_rdy", {31'b0, bus.rdy_rx}, 32'd0);

    start_txn(1'b1, "7 ");
    check_result("after_rst", 32'h0000_0007, 1'b0, 1'b0);
    finish_txn(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
